// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// Module   : fetch_if
// Brief    : Instruction-memory request bus plus decode-side output bus.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic [31:0]   imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_PC;
    logic [AW-1:0] out_PC_4;
    logic [31:0]   out_inst;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rdata,
        output out_valid, out_PC, out_PC_4, out_inst,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rdata,
        input  out_valid, out_PC, out_PC_4, out_inst,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// Module   : fetch_unit
// Brief    : Sequential instruction fetcher with a DEPTH-entry fetch queue.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter int AW    = 32,
    parameter int DEPTH = 4,
    parameter int STEP  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [AW-1:0] PC_START,
    input  wire logic          redirect,
    input  wire logic [AW-1:0] PC_IN,
    fetch_if.master            bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] c_STEP      = AW'(STEP);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_req_pc;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic [AW-1:0] r_q_pc   [DEPTH];
    logic [31:0]   r_q_inst [DEPTH];

    logic [CW-1:0] w_occ;
    logic          w_req;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;

    // Outstanding response counts as occupied so the queue can never overflow.
    assign w_occ  = r_count + {{(CW-1){1'b0}}, r_inflight};
    assign w_req  = ~rst & ~redirect & (w_occ < c_DEPTH_CNT);
    assign w_fire = w_req & bus.imem_gnt;
    assign w_push = r_inflight & ~redirect;
    assign w_pop  = (r_count != '0) & bus.out_ready & ~redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= PC_START;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_inflight <= 1'b0;
        end else if (redirect) begin
            r_pc       <= PC_IN;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + c_STEP;
            end
            r_inflight <= w_fire;
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_req_pc <= r_pc;
        end
        if (~rst & w_push) begin
            r_q_pc[r_tail]   <= r_req_pc;
            r_q_inst[r_tail] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_PC    = r_q_pc[r_head];
    assign bus.out_PC_4  = r_q_pc[r_head] + c_STEP;
    assign bus.out_inst  = r_q_inst[r_head];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// Module   : tb_fetch_unit
// Brief    : Directed per-cycle vector table plus hand sequences for fetch_unit.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] pc_in;
    logic        rst8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_if #(.AW(32)) bus  ();
    fetch_if #(.AW(8))  bus8 ();

    fetch_unit #(.AW(32), .DEPTH(4), .STEP(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .PC_START (32'h0000_1000),
        .redirect (redirect),
        .PC_IN    (pc_in),
        .bus      (bus)
    );

    fetch_unit #(.AW(8), .DEPTH(4), .STEP(4)) u_dut8 (
        .clk      (clk),
        .rst      (rst8),
        .PC_START (8'hF8),
        .redirect (1'b0),
        .PC_IN    (8'h00),
        .bus      (bus8)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory: data for an accepted request appears the following cycle.
    always @(posedge clk) begin
        bus.imem_rdata  <= (bus.imem_req && bus.imem_gnt) ? inst_of(bus.imem_addr) : 32'hDEAD_BEEF;
        bus8.imem_rdata <= (bus8.imem_req && bus8.imem_gnt) ? inst_of({24'h0, bus8.imem_addr}) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, ".val"},   {31'h0, bus.out_valid}, 32'h1);
        chk({tag, ".pc"},    bus.out_PC, pc);
        chk({tag, ".pc4"},   bus.out_PC_4, pc + 32'd4);
        chk({tag, ".inst"},  bus.out_inst, inst_of(pc));
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] pcin;
        logic        gnt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 24;
    vec_t tv [NV];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] pi,
                                input logic g, input logic y, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.redir = rd; v.pcin = pi; v.gnt = g; v.rdy = y;
        v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_pc = ep;
        return v;
    endfunction

    initial begin
        int grants;
        logic [7:0] exp8 [3];

        //             rst rd  pcin          g  y  req addr          val pc
        tv[0]  = mk(1, 0, 32'h0,      1, 1, 0, 32'h0,      0, 32'h0);
        tv[1]  = mk(0, 0, 32'h0,      1, 1, 1, 32'h1000,   0, 32'h0);
        tv[2]  = mk(0, 0, 32'h0,      1, 1, 1, 32'h1004,   0, 32'h0);
        tv[3]  = mk(0, 0, 32'h0,      1, 1, 1, 32'h1008,   1, 32'h1000);
        tv[4]  = mk(0, 0, 32'h0,      1, 1, 1, 32'h100C,   1, 32'h1004);
        tv[5]  = mk(0, 0, 32'h0,      0, 1, 1, 32'h1010,   1, 32'h1008);
        tv[6]  = mk(0, 0, 32'h0,      1, 1, 1, 32'h1010,   1, 32'h100C);
        tv[7]  = mk(0, 0, 32'h0,      0, 1, 1, 32'h1014,   0, 32'h0);
        tv[8]  = mk(0, 0, 32'h0,      1, 1, 1, 32'h1014,   1, 32'h1010);
        tv[9]  = mk(0, 0, 32'h0,      0, 1, 1, 32'h1018,   0, 32'h0);
        tv[10] = mk(0, 0, 32'h0,      1, 0, 1, 32'h1018,   1, 32'h1014);
        tv[11] = mk(0, 0, 32'h0,      1, 0, 1, 32'h101C,   1, 32'h1014);
        tv[12] = mk(0, 0, 32'h0,      1, 0, 1, 32'h1020,   1, 32'h1014);
        tv[13] = mk(0, 1, 32'h2000,   1, 1, 0, 32'h1024,   1, 32'h1014);
        tv[14] = mk(0, 0, 32'h0,      1, 1, 1, 32'h2000,   0, 32'h0);
        tv[15] = mk(0, 0, 32'h0,      1, 1, 1, 32'h2004,   0, 32'h0);
        tv[16] = mk(0, 0, 32'h0,      1, 1, 1, 32'h2008,   1, 32'h2000);
        tv[17] = mk(0, 1, 32'h3000,   1, 1, 0, 32'h200C,   1, 32'h2004);
        tv[18] = mk(0, 1, 32'h4000,   1, 1, 0, 32'h3000,   0, 32'h0);
        tv[19] = mk(0, 0, 32'h0,      1, 1, 1, 32'h4000,   0, 32'h0);
        tv[20] = mk(0, 0, 32'h0,      1, 1, 1, 32'h4004,   0, 32'h0);
        tv[21] = mk(0, 0, 32'h0,      1, 1, 1, 32'h4008,   1, 32'h4000);
        tv[22] = mk(1, 1, 32'h5000,   1, 1, 0, 32'h0,      1, 32'h4004);
        tv[23] = mk(0, 0, 32'h0,      1, 1, 1, 32'h1000,   0, 32'h0);

        rst = 1'b1; redirect = 1'b0; pc_in = '0;
        bus.imem_gnt = 1'b0; bus.out_ready = 1'b0;
        rst8 = 1'b1; bus8.imem_gnt = 1'b1; bus8.out_ready = 1'b1;
        step();
        step();

        // Per-cycle vector table: latency, gnt toggling, redirects, reset priority.
        for (int i = 0; i < NV; i++) begin
            rst = tv[i].rst; redirect = tv[i].redir; pc_in = tv[i].pcin;
            bus.imem_gnt = tv[i].gnt; bus.out_ready = tv[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d.req", i), {31'h0, bus.imem_req}, {31'h0, tv[i].e_req});
            if (!tv[i].rst)
                chk($sformatf("v%0d.addr", i), bus.imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d.val", i), {31'h0, bus.out_valid}, {31'h0, tv[i].e_val});
            if (tv[i].e_val)
                chk_head($sformatf("v%0d", i), tv[i].e_pc);
            step();
        end

        // Stall with ready low: exactly DEPTH grants, then request gated off.
        rst = 1'b1; redirect = 1'b0; bus.imem_gnt = 1'b1; bus.out_ready = 1'b0;
        step();
        rst = 1'b0;
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) grants++;
            step();
        end
        chk("full.grants", grants, 4);
        @(negedge clk);
        chk("full.req", {31'h0, bus.imem_req}, 32'h0);
        chk("full.addr", bus.imem_addr, 32'h1010);
        chk_head("full", 32'h1000);
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("pop1.req", {31'h0, bus.imem_req}, 32'h0);
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("resume.req", {31'h0, bus.imem_req}, 32'h1);
        chk("resume.addr", bus.imem_addr, 32'h1010);
        chk_head("resume", 32'h1004);
        step();
        @(negedge clk);
        chk("refull.req", {31'h0, bus.imem_req}, 32'h0);
        chk("refull.addr", bus.imem_addr, 32'h1014);

        // Reset mid-stream with a full queue and a response in flight.
        step();
        rst = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst0.req", {31'h0, bus.imem_req}, 32'h0);
        step();
        @(negedge clk);
        chk("rst1.req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst1.val", {31'h0, bus.out_valid}, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rs0.req", {31'h0, bus.imem_req}, 32'h1);
        chk("rs0.addr", bus.imem_addr, 32'h1000);
        chk("rs0.val", {31'h0, bus.out_valid}, 32'h0);
        step();
        @(negedge clk);
        chk("rs1.val", {31'h0, bus.out_valid}, 32'h0);
        step();
        @(negedge clk);
        chk_head("rs2", 32'h1000);

        // 8-bit address wrap.
        step();
        rst8 = 1'b0;
        step();
        step();
        exp8[0] = 8'hF8; exp8[1] = 8'hFC; exp8[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("w%0d.val", k), {31'h0, bus8.out_valid}, 32'h1);
            chk($sformatf("w%0d.pc", k), {24'h0, bus8.out_PC}, {24'h0, exp8[k]});
            chk($sformatf("w%0d.pc4", k), {24'h0, bus8.out_PC_4}, {24'h0, exp8[k] + 8'h04});
            chk($sformatf("w%0d.inst", k), bus8.out_inst, inst_of({24'h0, exp8[k]}));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter AW, default 32: PC/address width, >= 8.
REQ-002 Parameter DEPTH, default 4: fetch-queue entries, power of 2, >= 2.
REQ-003 Parameter STEP, default 4: PC increment in bytes.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 PC_START  in  AW  reset vector, sampled while rst=1.
REQ-007 redirect  in  1  taken branch/jump; flush and refetch from PC_IN.
REQ-008 PC_IN  in  AW  redirect target.
REQ-009 imem_req  out  1  fetch request valid.
REQ-010 imem_addr  out  AW  fetch address; equals internal PC.
REQ-011 imem_gnt  in  1  memory accepts request this cycle.
REQ-012 imem_rdata  in  32  instruction; valid exactly 1 cycle after an accepted request.
REQ-013 out_valid  out  1  queue head valid.
REQ-014 out_ready  in  1  decode accepts head (deasserted = stall).
REQ-015 out_PC  out  AW  PC of head instruction.
REQ-016 out_PC_4  out  AW  out_PC + STEP, modulo 2^AW.
REQ-017 out_inst  out  32  head instruction.

Function
REQ-018 Internal state: PC register, DEPTH-entry circular queue {PC, inst}, head/tail pointers, occupancy count (0..DEPTH), 1-bit inflight flag.
REQ-019 imem_req = ~rst & ~redirect & (count + inflight < DEPTH); combinational.
REQ-020 Accepted request (imem_req & imem_gnt): PC <= PC + STEP (wraps modulo 2^AW); inflight <= 1; request PC captured for the response.
REQ-021 imem_req & ~imem_gnt: PC, inflight unchanged; imem_addr held stable until granted or redirected.
REQ-022 No accepted request in a cycle: inflight <= 0 at next edge.
REQ-023 Response cycle (inflight=1, no flush): {captured PC, imem_rdata} written at tail; tail advances, wraps DEPTH-1 -> 0.
REQ-024 Pop: out_valid & out_ready advances head, wraps DEPTH-1 -> 0.
REQ-025 out_valid = (count != 0); out_PC/out_PC_4/out_inst from head entry; undefined-but-stable when empty.
REQ-026 Push and pop in same cycle: count unchanged, both pointers advance; legal when full (count=DEPTH only if no push, guaranteed by REQ-019).
REQ-027 Pop on empty queue is ignored.
REQ-028 Queue never overflows: request gated so count + inflight <= DEPTH at all times.
REQ-029 Throughput: with imem_gnt=1 and out_ready=1 continuously, one instruction per cycle after 2-cycle initial latency (request cycle, response cycle, out_valid next).
REQ-030 redirect=1: next edge PC <= PC_IN, count <= 0, head <= tail <= 0, inflight <= 0; response arriving in redirect cycle discarded; pop in redirect cycle discarded.
REQ-031 redirect has priority over pop, push and request; first request to PC_IN issued the cycle after redirect.
REQ-032 Back-to-back redirects: last one wins; each flushes.
REQ-033 out_ready=0 with full queue: no requests, PC held; resumes the cycle after a pop frees a slot.

Reset
REQ-034 While rst=1, each edge: PC <= PC_START, count <= 0, head <= tail <= 0, inflight <= 0; imem_req=0.
REQ-035 rst overrides redirect and all traffic, including mid-fetch; inflight response dropped.
REQ-036 After rst deasserts: out_valid=0; first request at PC_START in first post-reset cycle.

Verification
REQ-037 Reset with PC_START=0x1000, gnt=1, ready=1 -> imem_addr 0x1000,0x1004,...; out_PC 0x1000 with out_PC_4 0x1004 two cycles after rst falls, then one per cycle.
REQ-038 ready=0 from start, DEPTH=4 -> exactly 4 grants, count=4, imem_req=0; raising ready for one cycle -> one pop, one new request next cycle.
REQ-039 Redirect to 0x2000 while queue holds 3 and a response is in flight -> out_valid=0 next cycle, response dropped, next imem_addr=0x2000, next out_PC=0x2000.
REQ-040 gnt toggling 1,0,1,0 -> imem_addr held during gnt=0 cycles; out_PC sequence contiguous, no duplicates or gaps.
REQ-041 AW=8, PC_START=0xF8 -> out_PC 0xF8,0xFC,0x00; out_PC_4 of 0xFC is 0x00.
REQ-042 rst asserted mid-stream with full queue -> next cycle out_valid=0, imem_req=0 while rst held; restart at PC_START.
